// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result-producer and CDB broadcast signals for cdb_arbiter
//   alu_valid/alu_tag/alu_value -> ALU result offer, alu_ready <- ALU FIFO not full
//   lsb_valid/lsb_tag/lsb_value -> LSB result offer, lsb_ready <- LSB FIFO not full
//   cdb_valid/cdb_tag/cdb_value/cdb_src <- registered broadcast (src 0 = ALU, 1 = LSB)
//   master: producers and CDB consumers; slave: the arbiter
interface cdb_arbiter_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    logic              alu_valid;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_value;
    logic              alu_ready;
    logic              lsb_valid;
    logic [TAG_W-1:0]  lsb_tag;
    logic [DATA_W-1:0] lsb_value;
    logic              lsb_ready;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              cdb_src;

    modport master (
        output alu_valid, alu_tag, alu_value, lsb_valid, lsb_tag, lsb_value,
        input  alu_ready, lsb_ready, cdb_valid, cdb_tag, cdb_value, cdb_src
    );

    modport slave (
        input  alu_valid, alu_tag, alu_value, lsb_valid, lsb_tag, lsb_value,
        output alu_ready, lsb_ready, cdb_valid, cdb_tag, cdb_value, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between the ALU and the load/store buffer
//   clk_in   : clock, rising edge
//   rst_in   : asynchronous active-high reset
//   rdy_in   : global pause when low (all state holds)
//   flush_in : misprediction flush, empties both FIFOs and drops the broadcast
//   bus      : cdb_arbiter_if.slave (producer offers/readies and the CDB broadcast)
// Each producer feeds a private QDEPTH-entry FIFO; one head per cycle is granted
// onto the registered CDB, round-robin when both FIFOs hold results.
// Define CDB_FIXED_PRIO_EN to make contested grants always go to the LSB.
module cdb_arbiter #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int QDEPTH = 2
) (
    input logic         clk_in,
    input logic         rst_in,
    input logic         rdy_in,
    input logic         flush_in,
    cdb_arbiter_if.slave bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int EW = TAG_W + DATA_W;

    logic [EW-1:0]     alu_mem [QDEPTH];
    logic [EW-1:0]     lsb_mem [QDEPTH];
    logic [AW-1:0]     alu_wr, alu_rd, lsb_wr, lsb_rd;
    logic [AW:0]       alu_cnt, lsb_cnt;
    logic              alu_ready, lsb_ready, alu_push, lsb_push, alu_pop, lsb_pop;
    logic              gnt, gnt_lsb;
    logic [EW-1:0]     head;
    logic              cdb_valid, cdb_src;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
`ifndef CDB_FIXED_PRIO_EN
    logic              last_grant;
`endif

    // QDEPTH is a power of two, so the count MSB is set exactly when full
    assign alu_ready = !alu_cnt[AW];
    assign lsb_ready = !lsb_cnt[AW];
    assign alu_push  = bus.alu_valid && alu_ready;
    assign lsb_push  = bus.lsb_valid && lsb_ready;
    assign gnt       = alu_cnt != '0 || lsb_cnt != '0;
`ifdef CDB_FIXED_PRIO_EN
    assign gnt_lsb   = lsb_cnt != '0;
`else
    assign gnt_lsb   = lsb_cnt != '0 && (alu_cnt == '0 || !last_grant);
`endif
    assign alu_pop   = gnt && !gnt_lsb;
    assign lsb_pop   = gnt_lsb;
    assign head      = gnt_lsb ? lsb_mem[lsb_rd] : alu_mem[alu_rd];

    assign bus.alu_ready = alu_ready;
    assign bus.lsb_ready = lsb_ready;
    assign bus.cdb_valid = cdb_valid;
    assign bus.cdb_tag   = cdb_tag;
    assign bus.cdb_value = cdb_value;
    assign bus.cdb_src   = cdb_src;

    // Storage needs no reset: the counts alone decide what is valid
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_in && alu_push) alu_mem[alu_wr] <= {bus.alu_tag, bus.alu_value};
        if (rdy_in && !flush_in && lsb_push) lsb_mem[lsb_wr] <= {bus.lsb_tag, bus.lsb_value};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            alu_wr    <= '0;
            alu_rd    <= '0;
            alu_cnt   <= '0;
            lsb_wr    <= '0;
            lsb_rd    <= '0;
            lsb_cnt   <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= 1'b0;
`ifndef CDB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else if (flush_in) begin
            // Pointers are realigned too, so an empty FIFO always has rd == wr
            alu_wr    <= '0;
            alu_rd    <= '0;
            alu_cnt   <= '0;
            lsb_wr    <= '0;
            lsb_rd    <= '0;
            lsb_cnt   <= '0;
            cdb_valid <= 1'b0;
        end else if (rdy_in) begin
            alu_wr    <= alu_wr + AW'(alu_push);
            alu_rd    <= alu_rd + AW'(alu_pop);
            alu_cnt   <= alu_cnt + (AW+1)'(alu_push) - (AW+1)'(alu_pop);
            lsb_wr    <= lsb_wr + AW'(lsb_push);
            lsb_rd    <= lsb_rd + AW'(lsb_pop);
            lsb_cnt   <= lsb_cnt + (AW+1)'(lsb_push) - (AW+1)'(lsb_pop);
            cdb_valid <= gnt;
            if (gnt) begin
                cdb_tag   <= head[EW-1:DATA_W];
                cdb_value <= head[DATA_W-1:0];
                cdb_src   <= gnt_lsb;
`ifndef CDB_FIXED_PRIO_EN
                last_grant <= gnt_lsb;
`endif
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter (TAG_W=4, DATA_W=32, QDEPTH=2)
//   per-cycle vector table with hand-computed outputs, plus sequences for
//   mid-stream reset, contention order and LSB back-pressure
module tb_cdb_arbiter;
    logic clk_in = 1'b0;
    logic rst_in, rdy_in, flush_in;
    int checks = 0;
    int errors = 0;

    cdb_arbiter_if #(.TAG_W(4), .DATA_W(32)) bus ();

    cdb_arbiter #(.TAG_W(4), .DATA_W(32), .QDEPTH(2)) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rdy_in  (rdy_in),
        .flush_in(flush_in),
        .bus     (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        rdy, flush, av;
        logic [3:0]  at;
        logic [31:0] avl;
        logic        lv;
        logic [3:0]  lt;
        logic [31:0] lvl;
        logic        ar, lr, cv;
        logic [3:0]  ct;
        logic [31:0] cval;
        logic        cs;
    } vec_t;

    vec_t v [25];

    function automatic vec_t mk(input logic r, input logic f, input logic av, input logic [3:0] at,
                                input logic [31:0] avl, input logic lv, input logic [3:0] lt,
                                input logic [31:0] lvl, input logic ar, input logic lr, input logic cv,
                                input logic [3:0] ct, input logic [31:0] cval, input logic cs);
        vec_t x;
        x.rdy = r; x.flush = f; x.av = av; x.at = at; x.avl = avl;
        x.lv = lv; x.lt = lt; x.lvl = lvl;
        x.ar = ar; x.lr = lr; x.cv = cv; x.ct = ct; x.cval = cval; x.cs = cs;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic av, input logic [3:0] at,
                         input logic [31:0] avl, input logic lv, input logic [3:0] lt, input logic [31:0] lvl);
        rdy_in = r;
        flush_in = f;
        bus.alu_valid = av;
        bus.alu_tag = at;
        bus.alu_value = avl;
        bus.lsb_valid = lv;
        bus.lsb_tag = lt;
        bus.lsb_value = lvl;
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    logic [3:0] q_tag [$];
    logic       q_src [$];
    logic [3:0] l_out [$];
    logic [3:0] a_out [$];
    logic [3:0] exp_tag [4];
    logic       exp_src [4];

    initial begin
        rst_in = 1'b1;
        idle();
        step();
        step();
        rst_in = 1'b0;
        chk("reset cdb_valid", bus.cdb_valid, 0);
        chk("reset cdb_tag", bus.cdb_tag, 0);
        chk("reset cdb_value", bus.cdb_value, 0);
        chk("reset cdb_src", bus.cdb_src, 0);
        chk("reset alu_ready", bus.alu_ready, 1);
        chk("reset lsb_ready", bus.lsb_ready, 1);

        //        rdy f av at  avl      lv lt  lvl      ar lr cv ct  cval     cs
        v[0]  = mk(1, 0, 1, 3, 32'h11, 0, 0, 0,       1, 1, 0, 0, 0,       0);
        v[1]  = mk(1, 0, 0, 0, 0,      0, 0, 0,       1, 1, 1, 3, 32'h11,  0);
        v[2]  = mk(1, 0, 0, 0, 0,      0, 0, 0,       1, 1, 0, 3, 32'h11,  0);
        v[3]  = mk(1, 0, 0, 0, 0,      1, 4, 32'h44,  1, 1, 0, 3, 32'h11,  0);
        v[4]  = mk(1, 0, 0, 0, 0,      0, 0, 0,       1, 1, 1, 4, 32'h44,  1);
        v[5]  = mk(0, 0, 0, 0, 0,      1, 10, 32'haa, 1, 1, 1, 4, 32'h44,  1);
        v[6]  = mk(0, 0, 0, 0, 0,      1, 10, 32'haa, 1, 1, 1, 4, 32'h44,  1);
        v[7]  = mk(0, 0, 0, 0, 0,      1, 10, 32'haa, 1, 1, 1, 4, 32'h44,  1);
        v[8]  = mk(1, 0, 0, 0, 0,      1, 10, 32'haa, 1, 1, 0, 4, 32'h44,  1);
        v[9]  = mk(1, 0, 0, 0, 0,      0, 0, 0,       1, 1, 1, 10, 32'haa, 1);
        v[10] = mk(1, 0, 0, 0, 0,      0, 0, 0,       1, 1, 0, 10, 32'haa, 1);
        v[11] = mk(1, 0, 1, 1, 32'h1,  1, 2, 32'h2,   1, 1, 0, 10, 32'haa, 1);
        v[12] = mk(1, 0, 1, 3, 32'h3,  1, 4, 32'h4,   1, 0, 1, 1, 32'h1,   0);
        v[13] = mk(1, 0, 1, 5, 32'h5,  1, 6, 32'h6,   0, 1, 1, 2, 32'h2,   1);
        v[14] = mk(1, 1, 1, 7, 32'h7,  1, 8, 32'h8,   1, 1, 0, 2, 32'h2,   1);
        v[15] = mk(1, 0, 0, 0, 0,      0, 0, 0,       1, 1, 0, 2, 32'h2,   1);
        v[16] = mk(1, 0, 0, 0, 0,      0, 0, 0,       1, 1, 0, 2, 32'h2,   1);
        v[17] = mk(1, 0, 1, 12, 32'hc, 0, 0, 0,       1, 1, 0, 2, 32'h2,   1);
        v[18] = mk(1, 0, 1, 13, 32'hd, 0, 0, 0,       1, 1, 1, 12, 32'hc,  0);
        v[19] = mk(0, 1, 0, 0, 0,      0, 0, 0,       1, 1, 0, 12, 32'hc,  0);
        v[20] = mk(1, 0, 0, 0, 0,      0, 0, 0,       1, 1, 0, 12, 32'hc,  0);
        v[21] = mk(1, 0, 1, 14, 32'he, 1, 15, 32'hf,  1, 1, 0, 12, 32'hc,  0);
        v[22] = mk(1, 0, 0, 0, 0,      0, 0, 0,       1, 1, 1, 15, 32'hf,  1);
        v[23] = mk(1, 0, 0, 0, 0,      0, 0, 0,       1, 1, 1, 14, 32'he,  0);
        v[24] = mk(1, 0, 0, 0, 0,      0, 0, 0,       1, 1, 0, 14, 32'he,  0);

        for (int i = 0; i < 25; i++) begin
            drive(v[i].rdy, v[i].flush, v[i].av, v[i].at, v[i].avl, v[i].lv, v[i].lt, v[i].lvl);
            step();
            chk($sformatf("vec%0d alu_ready", i), bus.alu_ready, v[i].ar);
            chk($sformatf("vec%0d lsb_ready", i), bus.lsb_ready, v[i].lr);
            chk($sformatf("vec%0d cdb_valid", i), bus.cdb_valid, v[i].cv);
            chk($sformatf("vec%0d cdb_tag", i), bus.cdb_tag, v[i].ct);
            chk($sformatf("vec%0d cdb_value", i), bus.cdb_value, v[i].cval);
            chk($sformatf("vec%0d cdb_src", i), bus.cdb_src, v[i].cs);
        end

        // Reset asserted between edges with the ALU FIFO full and a broadcast live
        do_reset();
        drive(1, 0, 1, 1, 32'h101, 1, 5, 32'h505);
        step();
        drive(1, 0, 1, 2, 32'h102, 0, 0, 0);
        step();
        drive(1, 0, 1, 3, 32'h103, 0, 0, 0);
        step();
        idle();
        chk("mid alu_ready before reset", bus.alu_ready, 0);
        chk("mid cdb_valid before reset", bus.cdb_valid, 1);
        #2 rst_in = 1'b1;
        #1;
        chk("async cdb_valid", bus.cdb_valid, 0);
        chk("async alu_ready", bus.alu_ready, 1);
        chk("async cdb_tag", bus.cdb_tag, 0);
        #1 rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post reset cdb_valid %0d", i), bus.cdb_valid, 0);
        end

        // Contention: same-edge pushes from both sources
`ifdef CDB_FIXED_PRIO_EN
        exp_tag = '{4'd5, 4'd6, 4'd1, 4'd2};
        exp_src = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
        exp_tag = '{4'd1, 4'd5, 4'd2, 4'd6};
        exp_src = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        do_reset();
        drive(1, 0, 1, 1, 32'h1, 1, 5, 32'h5);
        step();
        drive(1, 0, 1, 2, 32'h2, 1, 6, 32'h6);
        step();
        if (bus.cdb_valid) begin q_tag.push_back(bus.cdb_tag); q_src.push_back(bus.cdb_src); end
        idle();
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.cdb_valid) begin q_tag.push_back(bus.cdb_tag); q_src.push_back(bus.cdb_src); end
        end
        chk("contention count", q_tag.size(), 4);
        for (int i = 0; i < 4 && i < q_tag.size(); i++) begin
            chk($sformatf("contention tag %0d", i), q_tag[i], exp_tag[i]);
            chk($sformatf("contention src %0d", i), q_src[i], exp_src[i]);
        end

        // Back-pressure: LSB holds each offer until accepted while the ALU streams
        do_reset();
        begin
            int a_next = 0;
            int l_idx = 0;
            int l_pushes = 0;
            logic a_acc, l_acc;
            for (int c = 0; c < 20; c++) begin
                drive(1, 0, a_next < 6, 4'(a_next), 32'h100 + a_next,
                      l_idx < 3, 4'(7 + l_idx), 32'h100 + 7 + l_idx);
                a_acc = bus.alu_valid && bus.alu_ready;
                l_acc = bus.lsb_valid && bus.lsb_ready;
                step();
                if (a_acc) a_next++;
                if (l_acc) begin
                    l_idx++;
                    l_pushes++;
`ifndef CDB_FIXED_PRIO_EN
                    if (l_pushes == 2) chk("bp lsb_ready after 2 pushes", bus.lsb_ready, 0);
`endif
                end
                if (bus.cdb_valid) begin
                    chk($sformatf("bp value c%0d", c), bus.cdb_value, 32'h100 + bus.cdb_tag);
                    if (bus.cdb_src) l_out.push_back(bus.cdb_tag);
                    else a_out.push_back(bus.cdb_tag);
                end
            end
        end
        chk("bp lsb count", l_out.size(), 3);
        for (int i = 0; i < 3 && i < l_out.size(); i++)
            chk($sformatf("bp lsb order %0d", i), l_out[i], 7 + i);
        chk("bp alu count", a_out.size(), 6);
        for (int i = 0; i < 6 && i < a_out.size(); i++)
            chk($sformatf("bp alu order %0d", i), a_out[i], i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the two result producers: the reservation-station ALU and the load/store buffer.
- Each producer pushes results (ROB tag and value) into a private small FIFO.
- One result per cycle is granted onto a registered CDB that feeds the ROB and the wake-up ports of the RS and LSB.
- Contested grants are round-robin; misprediction flush discards all queued results.

Parameters:
TAG_W, 4, width of ROB tag (matches ROB_WIDTH_BIT)
DATA_W, 32, result value width
QDEPTH, 2, entries per source FIFO (power of two, >=2)

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  reset; asynchronous, active-high
rdy_in  input  1  global pause when low
flush_in  input  1  ROB misprediction flush
alu_valid  input  1  ALU result offered
alu_tag  input  TAG_W  ROB tag of ALU result
alu_value  input  DATA_W  ALU result value
alu_ready  output  1  ALU FIFO not full
lsb_valid  input  1  LSB result offered
lsb_tag  input  TAG_W  ROB tag of LSB result
lsb_value  input  DATA_W  LSB result value
lsb_ready  output  1  LSB FIFO not full
cdb_valid  output  1  broadcast valid, one-cycle pulse per result
cdb_tag  output  TAG_W  broadcast ROB tag
cdb_value  output  DATA_W  broadcast value
cdb_src  output  1  0 = ALU, 1 = LSB

Behaviour:
- Reset (async, immediate): both FIFOs empty; cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0; last_grant=1 (LSB), so the first contested grant goes to ALU.
- alu_ready / lsb_ready: combinational, equal to count < QDEPTH. Both are 1 out of reset.
- Push: at an edge with rdy_in=1 and flush_in=0, x_valid && x_ready writes {tag, value} at the FIFO tail. Valid while not ready is dropped; the producer must hold it.
- Ready ignores a same-cycle pop. A full FIFO refuses a push even if it is popped that cycle.
- Grant is evaluated on FIFO contents at cycle start; a value pushed at edge E is not grantable before edge E+1.
  - Only one FIFO non-empty: that source is granted.
  - Both non-empty: the source != last_grant is granted.
  - Grant pops the head and updates last_grant.
  - Registers cdb_valid=1, cdb_tag, cdb_value, cdb_src at the same edge.
- No grant at an active edge: cdb_valid=0; tag, value and src hold.
- Minimum latency: offered at edge E, cdb_valid high during the cycle after edge E+1.
- Push and pop on the same FIFO at the same edge: both occur and count is unchanged. Pointers wrap modulo QDEPTH.
- Per-source order is strict FIFO. Cross-source order is arbitration-defined.
- rdy_in=0: all state and outputs hold, including a high cdb_valid. No push, no pop.
- flush_in=1 at an edge: applies regardless of rdy_in.
  - Both FIFOs empty; cdb_valid=0; same-cycle pushes discarded.
  - last_grant unchanged.
  - Flush outranks push and grant.
- Sustained contention with both FIFOs non-empty: grants alternate ALU, LSB, ALU, ...; neither source starves for more than 1 cycle.
- Throughput: at most one CDB result per cycle. Total sustained input above 1/cycle back-pressures via ready.

Optional Feature:
CDB_FIXED_PRIO_EN
- Defined: contested grants always go to LSB (loads unblock more dependents). last_grant is not implemented. ALU is granted only when the LSB FIFO is empty.
- Undefined: round-robin as specified above.

Test Plan:
- Reset mid-stream: ALU FIFO holding 2 entries, assert rst_in between edges -> cdb_valid=0 and alu_ready=1 immediately, before the next edge; no stale broadcast afterwards.
- Single source: alu push tag=3 value=0x11 at edge 0 -> after edge 1, cdb_valid=1, tag=3, value=0x11, src=0; after edge 2, cdb_valid=0.
- Contention: ALU tags 1,2 and LSB tags 5,6 pushed at the same two edges -> CDB tags in order 1,5,2,6 (fixed-prio build: 5,6,1,2).
- Back-pressure: QDEPTH=2, lsb_valid held with tags 7,8,9 while the ALU FIFO is continuously full and granted -> lsb_ready=0 after 2 pushes; tag 9 accepted only after a pop; output order 7,8,9, none lost.
- Pause: cdb_valid=1 with tag=4, then rdy_in=0 for 3 cycles with lsb_valid=1 -> CDB outputs frozen at tag 4, no push taken; resume gives a normal grant sequence.
- Flush: both FIFOs full plus alu_valid=1 at the flush edge -> after the edge, cdb_valid=0, both ready=1, and no queued tag ever appears on the CDB.
